// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if: requester-side byte streams plus the UART transmitter
// write port, bundled so the arbiter and its environment share one port list.
// master = requesters/transmitter side, slave = the arbiter itself.
interface uart_tx_arbiter_if #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
);
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0][7:0] req_data;   // requester i occupies bits [8i+7:8i]
    logic [NREQ-1:0]      req_last;
    logic [NREQ-1:0]      req_ready;
    logic                 tx_full;
    logic [7:0]           w_data;
    logic                 wr_uart;
    logic [IDW-1:0]       grant_id;
    logic                 busy;

    modport master (
        output req_valid, req_data, req_last, tx_full,
        input  req_ready, w_data, wr_uart, grant_id, busy
    );

    modport slave (
        input  req_valid, req_data, req_last, tx_full,
        output req_ready, w_data, wr_uart, grant_id, busy
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: message-atomic round-robin arbiter sharing one UART
// transmit write port among NREQ byte-stream requesters.
// Optional macro UART_TX_ARB_ID_PREFIX_EN: prefix each message with one
// ID byte (ID_BASE + grant_id) written before the owner's first byte.
module uart_tx_arbiter #(
    parameter int         NREQ    = 4,
    parameter int         IDW     = 2,
    parameter logic [7:0] ID_BASE = 8'h30
) (
    input  logic              clk,
    input  logic              reset,
    uart_tx_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE,
`ifdef UART_TX_ARB_ID_PREFIX_EN
        S_HDR,
`endif
        S_XFER
    } state_t;

    state_t         state_q, state_d;
    logic [IDW-1:0] grant_q, grant_d;
    logic [IDW-1:0] rr_q, rr_d;
    logic           busy_q, busy_d;

    logic [NREQ-1:0] req_ready_c;
    logic            wr_c;
    logic [7:0]      wdata_c;
    logic            found_c;
    logic [IDW-1:0]  pick_c;
    int              idx_c;

    // State register; reset drops any message in flight and restores the
    // pointer so requester 0 is searched first.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            grant_q <= '0;
            rr_q    <= IDW'(NREQ - 1);
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            rr_q    <= rr_d;
            busy_q  <= busy_d;
        end
    end

    // Next-state and write-port outputs; outputs depend only on registered
    // state plus the owner's live inputs, so the first byte goes out the
    // cycle after the grant is registered.
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        rr_d        = rr_q;
        busy_d      = busy_q;
        req_ready_c = '0;
        wr_c        = 1'b0;
        wdata_c     = 8'h00;
        found_c     = 1'b0;
        pick_c      = '0;
        idx_c       = 0;

        // Round-robin search starting just after the last finished owner,
        // which therefore has lowest priority.
        for (int k = 1; k <= NREQ; k++) begin
            idx_c = (int'(rr_q) + k) % NREQ;
            if (!found_c && bus.req_valid[idx_c[IDW-1:0]]) begin
                found_c = 1'b1;
                pick_c  = idx_c[IDW-1:0];
            end
        end

        unique case (state_q)
            S_IDLE: begin
                if (found_c) begin
                    grant_d = pick_c;
                    busy_d  = 1'b1;
`ifdef UART_TX_ARB_ID_PREFIX_EN
                    state_d = S_HDR;
`else
                    state_d = S_XFER;
`endif
                end
            end
`ifdef UART_TX_ARB_ID_PREFIX_EN
            S_HDR: begin
                wr_c    = !bus.tx_full;
                wdata_c = ID_BASE + 8'(grant_q);
                if (!bus.tx_full) state_d = S_XFER;
            end
`endif
            S_XFER: begin
                // Owner keeps the port until its last byte is accepted,
                // even if it withdraws valid for a while.
                req_ready_c[grant_q] = !bus.tx_full;
                wr_c    = bus.req_valid[grant_q] & !bus.tx_full;
                wdata_c = bus.req_data[grant_q];
                if (wr_c && bus.req_last[grant_q]) begin
                    rr_d    = grant_q;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.req_ready = req_ready_c;
    assign bus.wr_uart   = wr_c;
    assign bus.w_data    = wdata_c;
    assign bus.grant_id  = grant_q;
    assign bus.busy      = busy_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed test-plan scenarios plus randomized traffic,
// checked cycle by cycle against a byte-level reference model of the
// arbitration rules, and by logs of written bytes / grant order.
module tb_uart_tx_arbiter;
    localparam int         NREQ    = 4;
    localparam int         IDW     = 2;
    localparam logic [7:0] ID_BASE = 8'h30;
`ifdef UART_TX_ARB_ID_PREFIX_EN
    localparam bit PFX = 1'b1;
`else
    localparam bit PFX = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    uart_tx_arbiter_if #(.NREQ(NREQ), .IDW(IDW)) bus ();

    uart_tx_arbiter #(.NREQ(NREQ), .IDW(IDW), .ID_BASE(ID_BASE)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    endtask

    // Per-requester pending bytes {last, data} as ring buffers.
    logic [8:0] qb [NREQ][256];
    int qh [NREQ];
    int qt [NREQ];

    function automatic int qcnt(input int i);
        return qt[i] - qh[i];
    endfunction

    task automatic qpush(input int i, input logic [7:0] d, input bit last);
        if (qcnt(i) < 250) begin
            qb[i][qt[i] % 256] = {last, d};
            qt[i]++;
        end
    endtask

    // Knobs: valid/full probability (percent) and generator mode
    // (0 = none, 1 = random 1..4 byte messages, 2 = endless 1-byte messages).
    int p_valid  = 100;
    int p_full   = 0;
    int gen_mode = 0;

    // Reference model: who owns the port and where the search resumes.
    int m_phase = 0;   // 0 idle, 1 id header, 2 transferring
    int m_busy  = 0;
    int m_g     = 0;
    int m_rr    = NREQ - 1;

    logic [7:0] wr_log [$];
    int         gnt_log [$];
    logic       prev_busy = 1'b0;

    task automatic step(input bit rst);
        logic [NREQ-1:0] exp_ready;
        bit              exp_wr;
        logic [7:0]      exp_data;
        reset = rst;
        for (int i = 0; i < NREQ; i++) begin
            if (qcnt(i) == 0) begin
                if (gen_mode == 2) qpush(i, 8'($urandom), 1'b1);
                else if (gen_mode == 1 && $urandom_range(0, 99) < 20) begin
                    int n = $urandom_range(1, 4);
                    for (int b = 0; b < n; b++) qpush(i, 8'($urandom), b == n - 1);
                end
            end
            if (qcnt(i) > 0) begin
                bus.req_valid[i] = ($urandom_range(0, 99) < p_valid);
                bus.req_data[i]  = qb[i][qh[i] % 256][7:0];
                bus.req_last[i]  = qb[i][qh[i] % 256][8];
            end else begin
                bus.req_valid[i] = 1'b0;
                bus.req_data[i]  = 8'($urandom);
                bus.req_last[i]  = 1'($urandom);
            end
        end
        bus.tx_full = ($urandom_range(0, 99) < p_full);

        @(negedge clk);
        exp_ready = '0;
        exp_wr    = 1'b0;
        exp_data  = 8'h00;
        if (m_phase == 1) begin
            exp_wr   = !bus.tx_full;
            exp_data = ID_BASE + 8'(m_g);
        end else if (m_phase == 2) begin
            exp_ready[m_g] = !bus.tx_full;
            exp_wr   = bus.req_valid[m_g] && !bus.tx_full;
            exp_data = bus.req_data[m_g];
        end
        check("busy", 32'(bus.busy), 32'(m_busy));
        check("grant_id", 32'(bus.grant_id), 32'(m_g));
        check("req_ready", 32'(bus.req_ready), 32'(exp_ready));
        check("wr_uart", 32'(bus.wr_uart), 32'(exp_wr));
        check("w_data", 32'(bus.w_data), 32'(exp_data));

        if (bus.wr_uart) wr_log.push_back(bus.w_data);
        if (bus.busy && !prev_busy) gnt_log.push_back(int'(bus.grant_id));
        prev_busy = bus.busy;

        // Requesters consume on handshake as the rules define it.
        for (int i = 0; i < NREQ; i++)
            if (bus.req_valid[i] && exp_ready[i]) qh[i]++;

        if (rst) begin
            m_phase = 0; m_busy = 0; m_g = 0; m_rr = NREQ - 1;
        end else if (m_phase == 0) begin
            for (int k = 1; k <= NREQ; k++) begin
                int idx = (m_rr + k) % NREQ;
                if (m_phase == 0 && bus.req_valid[idx]) begin
                    m_g = idx; m_busy = 1; m_phase = PFX ? 1 : 2;
                end
            end
        end else if (m_phase == 1) begin
            if (!bus.tx_full) m_phase = 2;
        end else if (exp_wr && bus.req_last[m_g]) begin
            m_rr = m_g; m_busy = 0; m_phase = 0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n);
        for (int c = 0; c < n; c++) step(1'b0);
    endtask

    task automatic clear_all();
        for (int i = 0; i < NREQ; i++) qh[i] = qt[i];
        wr_log.delete();
        gnt_log.delete();
    endtask

    initial begin
        for (int i = 0; i < NREQ; i++) begin qh[i] = 0; qt[i] = 0; end
        reset = 1'b1;
        bus.req_valid = '0; bus.req_data = '0; bus.req_last = '0; bus.tx_full = 1'b0;
        @(posedge clk); #1;
        step(1'b1);
        run(2);   // reset state observed with nothing requesting

        // Single requester: 41, 42(last) from req 1.
        clear_all();
        qpush(1, 8'h41, 1'b0); qpush(1, 8'h42, 1'b1);
        run(5);
        check("single_nwr", wr_log.size(), (PFX ? 3 : 2));
        check("single_b0", 32'(wr_log[PFX ? 1 : 0]), 32'h41);
        check("single_b1", 32'(wr_log[PFX ? 2 : 1]), 32'h42);
        check("single_gnt", gnt_log[0], 1);

        // Contention after reset: req 0 wins outright, then req 2.
        step(1'b1);
        clear_all();
        qpush(0, 8'hA0, 1'b0); qpush(0, 8'hA1, 1'b0); qpush(0, 8'hA2, 1'b1);
        qpush(2, 8'hB0, 1'b0); qpush(2, 8'hB1, 1'b1);
        run(12);
        check("cont_nwr", wr_log.size(), (PFX ? 7 : 5));
        check("cont_a0", 32'(wr_log[PFX ? 1 : 0]), 32'hA0);
        check("cont_a2", 32'(wr_log[PFX ? 3 : 2]), 32'hA2);
        check("cont_b0", 32'(wr_log[PFX ? 5 : 3]), 32'hB0);
        check("cont_b1", 32'(wr_log[PFX ? 6 : 4]), 32'hB1);
        check("cont_gnt0", gnt_log[0], 0);
        check("cont_gnt1", gnt_log[1], 2);

        // Back-pressure: 5 full cycles mid-message, no loss or repeat.
        clear_all();
        qpush(1, 8'hC0, 1'b0); qpush(1, 8'hC1, 1'b0);
        qpush(1, 8'hC2, 1'b0); qpush(1, 8'hC3, 1'b1);
        run(PFX ? 4 : 3);
        p_full = 100; run(5);
        check("bp_stall_nwr", wr_log.size(), (PFX ? 3 : 2));
        p_full = 0; run(5);
        check("bp_nwr", wr_log.size(), (PFX ? 5 : 4));
        check("bp_c2", 32'(wr_log[PFX ? 3 : 2]), 32'hC2);
        check("bp_c3", 32'(wr_log[PFX ? 4 : 3]), 32'hC3);

        // Fairness: everyone always valid with 1-byte messages.
        step(1'b1);
        clear_all();
        gen_mode = 2;
        run(PFX ? 20 : 14);
        gen_mode = 0;
        for (int k = 0; k < 6; k++) check("fair_gnt", gnt_log[k], k % NREQ);
        run(6);

        // Reset mid-message after the 2nd of 4 bytes from req 0.
        step(1'b1);
        clear_all();
        qpush(0, 8'hD0, 1'b0); qpush(0, 8'hD1, 1'b0);
        qpush(0, 8'hD2, 1'b0); qpush(0, 8'hD3, 1'b1);
        run(PFX ? 4 : 3);
        check("rst_pre_nwr", wr_log.size(), (PFX ? 3 : 2));
        p_full = 100; step(1'b1); p_full = 0;
        clear_all();
        qpush(3, 8'hE0, 1'b1);
        run(5);
        check("rst_gnt", gnt_log[0], 3);
        check("rst_nwr", wr_log.size(), (PFX ? 2 : 1));
        check("rst_e0", 32'(wr_log[PFX ? 1 : 0]), 32'hE0);

`ifdef UART_TX_ARB_ID_PREFIX_EN
        // ID prefix: req 2 sends 55 -> 32, 55.
        step(1'b1);
        clear_all();
        qpush(2, 8'h55, 1'b1);
        run(5);
        check("pfx_nwr", wr_log.size(), 2);
        check("pfx_id", 32'(wr_log[0]), 32'h32);
        check("pfx_b", 32'(wr_log[1]), 32'h55);
`endif

        // Randomized traffic with back-pressure, withdrawals, and resets.
        step(1'b1);
        clear_all();
        gen_mode = 1; p_valid = 80; p_full = 25;
        for (int c = 0; c < 3000; c++) step($urandom_range(0, 199) == 0);
        gen_mode = 0; p_valid = 100; p_full = 0;
        run(400);
        for (int i = 0; i < NREQ; i++) check("drain", qcnt(i), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
